// File: rtl/mips_mdu.sv
// Multi-cycle multiply/divide unit with private HI/LO for the MIPS E stage.
// Define MDU_DIV_EN to build the div/divu datapath; otherwise ops 3/4 act as no-ops.
module mips_mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       MDUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [2:0]    OP_MULT  = 3'd1;
    localparam logic [2:0]    OP_MULTU = 3'd2;
    localparam logic [2:0]    OP_MTHI  = 3'd5;
    localparam logic [2:0]    OP_MTLO  = 3'd6;
    localparam logic [CW-1:0] MULT_LD  = CW'(MULT_CYCLES);
`ifdef MDU_DIV_EN
    localparam logic [2:0]    OP_DIV   = 3'd3;
    localparam logic [2:0]    OP_DIVU  = 3'd4;
    localparam logic [CW-1:0] DIV_LD   = CW'(DIV_CYCLES);
`endif

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    function automatic logic is_long(input logic [2:0] op);
`ifdef MDU_DIV_EN
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`else
        return (op == OP_MULT) || (op == OP_MULTU);
`endif
    endfunction

    function automatic logic [CW-1:0] load_cnt(input logic [2:0] op);
`ifdef MDU_DIV_EN
        return ((op == OP_DIV) || (op == OP_DIVU)) ? DIV_LD : MULT_LD;
`else
        if (op == OP_MULT) return MULT_LD;
        return MULT_LD;
`endif
    endfunction

    // Products are taken from the latched operands so forwarded A/B may change while busy.
    logic signed [2*WIDTH-1:0] prod_s;
    logic        [2*WIDTH-1:0] prod_u;

    assign prod_s = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
    assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

`ifdef MDU_DIV_EN
    logic signed [WIDTH-1:0] q_s, r_s;
    logic        [WIDTH-1:0] q_u, r_u;
    logic                    div_zero, div_ovf;

    assign div_zero = (b_q == '0);
    assign div_ovf  = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);

    // Zero and overflow cases are steered away from the divider so it never sees them.
    always_comb begin
        q_s = '0;
        r_s = '0;
        q_u = '0;
        r_u = '0;
        if (div_ovf) begin
            q_s = $signed(a_q);
        end else if (!div_zero) begin
            q_s = $signed(a_q) / $signed(b_q);
            r_s = $signed(a_q) % $signed(b_q);
        end
        if (!div_zero) begin
            q_u = a_q / b_q;
            r_u = a_q % b_q;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_long(MDUOp)) begin
                        op_d    = MDUOp;
                        a_d     = A;
                        b_d     = B;
                        cnt_d   = load_cnt(MDUOp);
                        state_d = S_BUSY;
                    end else if (MDUOp == OP_MTHI) begin
                        hi_d = A;
                    end else if (MDUOp == OP_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    case (op_q)
                        OP_MULT:  {hi_d, lo_d} = prod_s;
                        OP_MULTU: {hi_d, lo_d} = prod_u;
`ifdef MDU_DIV_EN
                        OP_DIV: begin
                            if (!div_zero) begin
                                lo_d = q_s;
                                hi_d = r_s;
                            end
                        end
                        OP_DIVU: begin
                            if (!div_zero) begin
                                lo_d = q_u;
                                hi_d = r_u;
                            end
                        end
`endif
                        default: ;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        op_q <= op_d;
        a_q  <= a_d;
        b_q  <= b_d;
    end

    assign busy = (state_q == S_BUSY);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mips_mdu.sv
// Scoreboard bench for mips_mdu: vector table of multiplies plus hand-built
// sequences for mthi/mtlo, ignored mid-op starts, reset mid-op and divide handling.
module tb_mips_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  MDUOp;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO;

    always #5 clk = ~clk;

    mips_mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .MDUOp(MDUOp),
        .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[6];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;
    logic [31:0] ra, rb;
    longint      ps;
    logic [63:0] pe, pu;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one op, scramble A/B while busy, count busy cycles, then compare.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input int ec, input bit poke);
        exp_t e;
        int   cyc;
        start = 1'b1;
        MDUOp = op;
        A     = a;
        B     = b;
        e.hi  = eh;
        e.lo  = el;
        e.cyc = ec;
        sb.push_back(e);
        tick();
        start = 1'b0;
        MDUOp = 3'd0;
        A     = $urandom;
        B     = $urandom;
        cyc   = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            if (poke && cyc == 2) begin
                start = 1'b1;
                MDUOp = 3'd5;
                A     = 32'hDEADBEEF;
            end else begin
                start = 1'b0;
                MDUOp = 3'd0;
            end
            tick();
        end
        start = 1'b0;
        MDUOp = 3'd0;
        e = sb.pop_front();
        check_int({name, "_cycles"}, cyc, e.cyc);
        check32({name, "_hi"}, HI, e.hi);
        check32({name, "_lo"}, LO, e.lo);
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        MDUOp = 3'd0;
        A     = 32'h0;
        B     = 32'h0;

        vecs[0] = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[2] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
        vecs[3] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5};
        vecs[4] = '{3'd2, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, 5};
        vecs[5] = '{3'd1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 5};

        repeat (2) tick();
        check32("reset_busy", {31'b0, busy}, 32'h0);
        check32("reset_hi", HI, 32'h0);
        check32("reset_lo", LO, 32'h0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 6; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].cyc, 1'b0);

        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom;
            ps = longint'($signed(ra)) * longint'($signed(rb));
            pe = ps;
            run_op($sformatf("rmult%0d", i), 3'd1, ra, rb, pe[63:32], pe[31:0], 5, 1'b0);
            pu = {32'h0, ra} * {32'h0, rb};
            run_op($sformatf("rmultu%0d", i), 3'd2, ra, rb, pu[63:32], pu[31:0], 5, 1'b0);
        end

        run_op("mthi", 3'd5, 32'h12345678, 32'h0, 32'h12345678, m_lo, 0, 1'b0);
        run_op("mtlo", 3'd6, 32'h9ABCDEF0, 32'h0, 32'h12345678, 32'h9ABCDEF0, 0, 1'b0);
        run_op("none", 3'd0, 32'h55555555, 32'h1, m_hi, m_lo, 0, 1'b0);
        run_op("rsvd", 3'd7, 32'h55555555, 32'h1, m_hi, m_lo, 0, 1'b0);
        run_op("mult_poke", 3'd1, 32'h7, 32'h6, 32'h0, 32'd42, 5, 1'b1);

`ifdef MDU_DIV_EN
        run_op("div_neg", 3'd3, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b0);
        run_op("div_zero", 3'd3, 32'hFFFFFFF9, 32'h0, m_hi, m_lo, 10, 1'b0);
        run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10, 1'b0);
        run_op("div_negb", 3'd3, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 10, 1'b0);
        run_op("divu", 3'd4, 32'd10, 32'd3, 32'd1, 32'd3, 10, 1'b0);
        run_op("divu_big", 3'd4, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 10, 1'b0);
        MDUOp = 3'd3;
`else
        run_op("divu_off", 3'd4, 32'd10, 32'd3, m_hi, m_lo, 0, 1'b0);
        run_op("div_off", 3'd3, 32'hFFFFFFF9, 32'd2, m_hi, m_lo, 0, 1'b0);
        MDUOp = 3'd1;
`endif
        start = 1'b1;
        A     = 32'h00012345;
        B     = 32'h00000007;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check32("midop_busy", {31'b0, busy}, 32'h1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check32("midrst_busy", {31'b0, busy}, 32'h0);
        check32("midrst_hi", HI, 32'h0);
        check32("midrst_lo", LO, 32'h0);
        m_hi = 32'h0;
        m_lo = 32'h0;
        run_op("post_rst_mult", 3'd1, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
